// File: rtl/fifo_stream_reader.sv
// Drains a registered-output synchronous FIFO onto a valid/ready stream master.
// A credit-limited output queue absorbs the FIFO's one-cycle read latency.
module fifo_stream_reader #(
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic [15:0]       xfer_count
);
    localparam int unsigned IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);

    logic [DATA_W-1:0] queue_mem [BUF_DEPTH];
    logic [OCC_W-1:0]  occ;
    logic              inflight_q;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              capture;
    logic              pop;
    logic [OCC_W:0]    credit_used;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(BUF_DEPTH - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    // Credits count both queued bytes and the byte still on its way from the FIFO
    always_comb begin
        credit_used = (OCC_W + 1)'(occ) + (OCC_W + 1)'(inflight_q);
        fifo_rd_en  = rst && !fifo_empty && !flush &&
                      (credit_used < (OCC_W + 1)'(BUF_DEPTH));
        m_valid     = rst && (occ != '0);
        m_data      = m_valid ? queue_mem[rd_idx] : '0;
        busy        = rst && ((occ != '0) || inflight_q);
        capture     = inflight_q && !flush;
        pop         = m_valid && m_ready && !flush;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ        <= '0;
            inflight_q <= 1'b0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            xfer_count <= '0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (flush) begin
                occ    <= '0;
                wr_idx <= '0;
                rd_idx <= '0;
            end else begin
                if (capture) begin
                    wr_idx <= next_idx(wr_idx);
                end
                if (pop) begin
                    rd_idx     <= next_idx(rd_idx);
                    xfer_count <= xfer_count + 16'd1;
                end
                if (capture && !pop) begin
                    occ <= occ + OCC_W'(1);
                end else if (pop && !capture) begin
                    occ <= occ - OCC_W'(1);
                end
            end
        end
    end

    // Storage is deliberately not reset; it is only visible while m_valid is high
    always_ff @(posedge clk) begin
        if (capture) begin
            queue_mem[wr_idx] <= fifo_dout;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: FIFO model, stream scoreboard
// and randomized traffic including flush, underrun, reset and counter wrap.
module tb_fifo_stream_reader;
    localparam int unsigned BUF_DEPTH = 4;
    localparam int unsigned DATA_W    = 8;

    logic              clk        = 1'b0;
    logic              rst        = 1'b0;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_dout  = '0;
    logic              flush      = 1'b0;
    logic              m_valid;
    logic              m_ready    = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              busy;
    logic [15:0]       xfer_count;

    fifo_stream_reader #(.BUF_DEPTH(BUF_DEPTH), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    // Source FIFO model: registered read data, emptied by the shared reset
    logic [7:0] fmem [65536];
    int         wr_ptr     = 0;
    int         rd_ptr     = 0;
    logic       hold_empty = 1'b0;

    assign fifo_empty = hold_empty || (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_dout <= fmem[rd_ptr[15:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Scoreboard state: bytes visible to the consumer, and the byte in transit
    logic [7:0]  vis[$];
    logic        infl_v       = 1'b0;
    logic [7:0]  infl_d       = '0;
    logic [15:0] exp_xfer     = '0;
    logic        prev_rst_low = 1'b0;
    logic        stim_timeout = 1'b0;
    int          n_checks     = 0;
    int          n_errors     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare mid-cycle, then advance the model to the coming edge
    always @(negedge clk) begin
        int   held;
        logic have;
        if (!rst) begin
            check("rst_fifo_rd_en", 32'(fifo_rd_en), 32'(0));
            check("rst_m_valid",    32'(m_valid),    32'(0));
            check("rst_m_data",     32'(m_data),     32'(0));
            check("rst_busy",       32'(busy),       32'(0));
            if (prev_rst_low) begin
                check("rst_xfer_count", 32'(xfer_count), 32'(0));
            end
            vis.delete();
            infl_v       = 1'b0;
            exp_xfer     = '0;
            prev_rst_low = 1'b1;
        end else begin
            prev_rst_low = 1'b0;
            have = (vis.size() != 0);
            held = vis.size() + (infl_v ? 1 : 0);
            check("occupancy_bound", 32'(held <= BUF_DEPTH), 32'(1));
            check("fifo_rd_en", 32'(fifo_rd_en),
                  32'(!fifo_empty && !flush && (held < BUF_DEPTH)));
            check("m_valid", 32'(m_valid), 32'(have));
            check("m_data", 32'(m_data), 32'(have ? vis[0] : 8'h00));
            check("busy", 32'(busy), 32'(have || infl_v));
            check("xfer_count", 32'(xfer_count), 32'(exp_xfer));
            check("drain_timeout", 32'(stim_timeout), 32'(0));
            if (flush) begin
                vis.delete();
                infl_v = 1'b0;
            end else begin
                if (m_ready && have) begin
                    void'(vis.pop_front());
                    exp_xfer = exp_xfer + 16'd1;
                end
                if (infl_v) begin
                    vis.push_back(infl_d);
                end
                infl_v = 1'b0;
            end
            if (fifo_rd_en) begin
                infl_v = 1'b1;
                infl_d = fmem[rd_ptr[15:0]];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        fmem[wr_ptr[15:0]] = d;
        wr_ptr++;
    endtask

    task automatic drain(input int budget);
        int n;
        n          = 0;
        m_ready    = 1'b1;
        hold_empty = 1'b0;
        flush      = 1'b0;
        while ((vis.size() != 0 || infl_v || wr_ptr != rd_ptr) && n < budget) begin
            tick();
            n++;
        end
        if (vis.size() != 0 || infl_v || wr_ptr != rd_ptr) begin
            stim_timeout = 1'b1;
        end
    endtask

    initial begin
        int pushed;
        int cyc;

        // Reset held with a non-empty FIFO and a ready consumer
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            push(8'(8'hE0 + i));
        end
        tick();
        rst = 1'b1;

        // Plain streaming
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        drain(100);

        // Back-pressure, then toggled ready
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(8'(8'hA0 + i));
        repeat (10) tick();
        for (int i = 0; i < 40; i++) begin
            m_ready = ~m_ready;
            tick();
        end
        drain(100);

        // Flush while a byte is in flight
        m_ready = 1'b0;
        push(8'h01);
        push(8'h02);
        repeat (4) tick();
        push(8'h03);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        push(8'h04);
        m_ready = 1'b1;
        drain(100);

        // FIFO underrun: empty flag forced every other pair of cycles
        for (int i = 0; i < 30; i++) push(8'(8'h40 + i));
        for (int i = 0; i < 60; i++) begin
            hold_empty = ((i / 2) % 2) == 0;
            tick();
        end
        drain(200);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            m_ready    = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            hold_empty = ($urandom_range(0, 4) == 0);
            rst        = ($urandom_range(0, 599) != 0);
            if ((wr_ptr - rd_ptr) < 20 && $urandom_range(0, 2) != 0) begin
                push(8'($urandom));
            end
            tick();
        end
        rst = 1'b1;
        drain(200);

        // Long stream from reset to carry xfer_count through 0xFFFF -> 0x0000
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        m_ready = 1'b1;
        pushed  = 0;
        cyc     = 0;
        while (pushed < 65540 && cyc < 70000) begin
            if ((wr_ptr - rd_ptr) < 8) begin
                push(8'(pushed * 7));
                pushed++;
            end
            tick();
            cyc++;
        end
        if (pushed < 65540) stim_timeout = 1'b1;
        drain(200);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
